event_log_capture: RTL
======================

// Module: event_log_capture
// PURPOSE
//  Synthesizable event capture stage that feeds the testbench logger. DUT-side
//  agents raise tagged events (severity, verbosity level, payload), and this block
//  filters them against a runtime verbosity threshold and timestamps them. It
//  buffers them in a FIFO and streams them out over valid/ready to the monitor,
//  which formats them into INFO/WARNING/ERROR/FATAL log lines.
// PARAMETERS
//  DATA_WIDTH  32  event payload width
//  TS_WIDTH    32  free-running timestamp counter width
//  DEPTH_LOG2  4   FIFO depth = 2**DEPTH_LOG2 entries
//  DROP_WIDTH  16  saturating dropped-event counter width
// PORTS
//  clk            in   1           single clock
//  resetn         in   1           asynchronous active-low reset
//  verbosity_thr  in   2           runtime threshold: 0=NONE 1=LOW 2=MEDIUM 3=HIGH
//  cnt_clr        in   1           synchronous clear of timestamp, drop_count, fatal_seen
//  ev_valid       in   1           event strobe; no backpressure toward the DUT
//  ev_severity    in   2           0=INFO 1=WARNING 2=ERROR 3=FATAL
//  ev_level       in   2           message verbosity; only used for INFO
//  ev_data        in   DATA_WIDTH  payload
//  m_valid        out  1           output entry valid
//  m_ready        in   1           consumer ready
//  m_data         out  TS_WIDTH+DATA_WIDTH+5  {lost, severity, level, ts, data}
//  drop_count     out  DROP_WIDTH  events dropped on FIFO full; saturates at all-ones
//  fatal_seen     out  1           sticky; set by any accepted FATAL
//  fifo_level     out  DEPTH_LOG2+1 current occupancy
// BEHAVIOUR
//  Reset: m_valid=0, m_data=0, drop_count=0, fatal_seen=0, fifo_level=0,
//    timestamp=0, lost flag=0. All of these clear asynchronously on resetn low.
//  Timestamp: increments every cycle and wraps to 0 modulo 2**TS_WIDTH. Each event
//    is stamped with the counter value in its ev_valid cycle.
//  Filter: INFO is accepted iff verbosity_thr >= ev_level. WARNING, ERROR and
//    FATAL are always accepted, whatever the threshold.
//  Push: an accepted event is written when the FIFO is not full, or when it is
//    full and a pop occurs in the same cycle (the pop frees the slot first).
//  Drop: an accepted event that finds the FIFO full with no pop that cycle:
//    - drop_count increments and holds at max;
//    - the sticky lost flag is set.
//  Filtered events are never counted as drops.
//  Lost flag: copied into the lost field of the next written entry, then
//    cleared in that same cycle. If a drop and a write coincide, the flag stays
//    set for the entry after.
//  Output: the FIFO head is registered onto m_valid/m_data. Latency is 1 cycle:
//    an event at edge N into an empty FIFO gives m_valid=1 after edge N+1.
//  Handshake: a pop happens on m_valid & m_ready. m_data stays stable while
//    m_valid=1 & !m_ready. With back-to-back pops, m_valid=1 is sustained.
//  Empty: m_valid=0, and m_data holds its last value.
//  Pointers: DEPTH_LOG2+1 bits with a wrap bit; full/empty are decided from the
//    wrap bit.
//  cnt_clr: next cycle timestamp=0, drop_count=0, fatal_seen=0. FIFO contents
//    and the lost flag are untouched. An event in the cnt_clr cycle is stamped
//    with the pre-clear value. A drop in that cycle still leaves drop_count=0.
//  fatal_seen: set in the cycle after a FATAL is written; clears only on reset
//    or cnt_clr.
//  Mid-operation reset: all entries are discarded and m_valid falls
//    immediately (asynchronously).
// STRUCTURE
//  Package event_log_capture_pkg:
//    - severity_t enum (INFO, WARNING, ERROR, FATAL);
//    - level_t enum with values matching the logger verbosity (NONE=0..HIGH=3);
//    - log_entry_t packed struct, so the monitor decodes m_data by cast.
//  Sub-module log_capture_fifo: parameterized sync FIFO with registered head,
//    push/pop/full/empty/level. Filter, timestamp, drop and lost logic sit in
//    the top level.
// TESTING
//  1. thr=1, INFO level 2 then INFO level 1, m_ready=1 -> one entry, level=1,
//     lost=0.
//  2. thr=0, WARNING, ERROR, FATAL at consecutive cycles -> 3 entries in order;
//     fatal_seen=1 the cycle after the FATAL write.
//  3. m_ready=0, DEPTH=16, 20 accepted events -> fifo_level=16, drop_count=4.
//     Release m_ready and push event 21 -> it carries lost=1; later entries
//     carry lost=0.
//  4. FIFO full, push and pop in the same cycle -> written, drop_count
//     unchanged, fifo_level stays 16.
//  5. TS_WIDTH=4, events at cycle 15 and 16 after reset -> ts=15 then ts=0.
//     cnt_clr with drop_count=3 -> 0 next cycle.
//  6. resetn low while 5 entries are queued and m_valid=1 -> m_valid=0 at once.
//     After release: fifo_level=0, drop_count=0, first new event has ts equal to
//     cycles since release.

Source files
------------

// File: rtl/event_log_capture_pkg.sv
// Shared types for the event capture path and the monitor that decodes its output.
package event_log_capture_pkg;

    typedef enum logic [1:0] {
        SEV_INFO    = 2'd0,
        SEV_WARNING = 2'd1,
        SEV_ERROR   = 2'd2,
        SEV_FATAL   = 2'd3
    } severity_t;

    typedef enum logic [1:0] {
        LVL_NONE   = 2'd0,
        LVL_LOW    = 2'd1,
        LVL_MEDIUM = 2'd2,
        LVL_HIGH   = 2'd3
    } level_t;

    localparam int LOG_DATA_WIDTH = 32;
    localparam int LOG_TS_WIDTH   = 32;

    // Field order matches m_data for the default widths, so the monitor can cast directly.
    typedef struct packed {
        logic                      lost;
        severity_t                 severity;
        level_t                    level;
        logic [LOG_TS_WIDTH-1:0]   ts;
        logic [LOG_DATA_WIDTH-1:0] data;
    } log_entry_t;

    function automatic logic eventAccepted(input severity_t sev, input level_t lvl,
                                           input level_t thr);
        return (sev != SEV_INFO) || (thr >= lvl);
    endfunction

endpackage

// File: rtl/log_capture_fifo.sv
// Synchronous FIFO with a registered head: the head register always shows the oldest
// unpopped entry, loaded one edge after that entry became the oldest.
module log_capture_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [WIDTH-1:0]      pushData,
    input  logic                  popReady,
    output logic                  full,
    output logic                  popFire,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  headValid,
    output logic [WIDTH-1:0]      headData
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wrPtr;
    logic [DEPTH_LOG2:0] rdPtr;
    logic [DEPTH_LOG2:0] rdPtrNext;
    logic                emptyAfterPop;

    // Valid/ready: a pop happens on headValid & popReady; headData is held while
    // headValid is high and the consumer stalls, and also while the FIFO is empty.
    assign popFire       = headValid & popReady;
    assign full          = (wrPtr[DEPTH_LOG2] != rdPtr[DEPTH_LOG2]) &&
                           (wrPtr[DEPTH_LOG2-1:0] == rdPtr[DEPTH_LOG2-1:0]);
    assign level         = wrPtr - rdPtr;
    assign rdPtrNext     = rdPtr + {{DEPTH_LOG2{1'b0}}, popFire};
    assign emptyAfterPop = (wrPtr == rdPtrNext);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[DEPTH_LOG2-1:0]] <= pushData;
        end
    end

    // A push into a full FIFO with a pop reuses the slot just copied to the head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            headValid <= 1'b0;
            headData  <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + {{DEPTH_LOG2{1'b0}}, 1'b1};
            end
            rdPtr     <= rdPtrNext;
            headValid <= ~emptyAfterPop;
            if (!emptyAfterPop) begin
                headData <= mem[rdPtrNext[DEPTH_LOG2-1:0]];
            end
        end
    end

endmodule

// File: rtl/event_log_capture.sv
// Filters tagged events by verbosity, timestamps them and queues them for the log monitor;
// overflow is reported through a saturating drop counter and a lost marker on the next entry.
module event_log_capture
    import event_log_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int DROP_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [1:0]                     verbosity_thr,
    input  logic                           cnt_clr,
    input  logic                           ev_valid,
    input  logic [1:0]                     ev_severity,
    input  logic [1:0]                     ev_level,
    input  logic [DATA_WIDTH-1:0]          ev_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [TS_WIDTH+DATA_WIDTH+4:0] m_data,
    output logic [DROP_WIDTH-1:0]          drop_count,
    output logic                           fatal_seen,
    output logic [DEPTH_LOG2:0]            fifo_level
);

    localparam int ENTRY_W = TS_WIDTH + DATA_WIDTH + 5;

    logic [TS_WIDTH-1:0] timestamp;
    logic                lostFlag;
    logic                fifoFull;
    logic                popFire;
    logic                accepted;
    logic                pushEn;
    logic                dropEv;
    logic [ENTRY_W-1:0]  pushEntry;

    assign accepted  = ev_valid & eventAccepted(severity_t'(ev_severity), level_t'(ev_level),
                                                level_t'(verbosity_thr));
    assign pushEn    = accepted & (~fifoFull | popFire);
    assign dropEv    = accepted & fifoFull & ~popFire;
    assign pushEntry = {lostFlag, ev_severity, ev_level, timestamp, ev_data};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timestamp  <= '0;
            lostFlag   <= 1'b0;
            drop_count <= '0;
            fatal_seen <= 1'b0;
        end else begin
            timestamp <= cnt_clr ? '0 : timestamp + TS_WIDTH'(1);

            // The written entry carries the old flag, so it clears on the same edge.
            if (pushEn) begin
                lostFlag <= 1'b0;
            end else if (dropEv) begin
                lostFlag <= 1'b1;
            end

            if (cnt_clr) begin
                drop_count <= '0;
            end else if (dropEv && !(&drop_count)) begin
                drop_count <= drop_count + DROP_WIDTH'(1);
            end

            if (cnt_clr) begin
                fatal_seen <= 1'b0;
            end else if (pushEn && (severity_t'(ev_severity) == SEV_FATAL)) begin
                fatal_seen <= 1'b1;
            end
        end
    end

    log_capture_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) uFifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (pushEn),
        .pushData  (pushEntry),
        .popReady  (m_ready),
        .full      (fifoFull),
        .popFire   (popFire),
        .level     (fifo_level),
        .headValid (m_valid),
        .headData  (m_data)
    );

endmodule
